// File: rtl/shared_key_schedule_ctrl.sv
// Shared (Boolean-masked) key-schedule controller with a round-key buffer.
// Optional REMASK_STORE_EN remasks every stored entry with fresh randomness.
module shared_key_schedule_ctrl #(
    parameter int KW     = 128,
    parameter int SHARES = 2,
    parameter int NR     = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [SHARES*KW-1:0]   mkey,
    input  logic [(SHARES-1)*KW-1:0] rnd,
    output logic                   busy,
    output logic                   done,
    output logic [SHARES*KW-1:0]   rf_key_out,
    output logic                   rf_rc_ena,
    input  logic [SHARES*KW-1:0]   rf_key_in,
    input  logic                   rk_rd_en,
    input  logic [4:0]             rk_rd_addr,
    output logic [SHARES*KW-1:0]   rk_rd_data,
    output logic                   rk_rd_valid
);

    localparam int W = SHARES * KW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_t;

    state_t         state;
    logic [4:0]     rc;
    logic [W-1:0]   chain;
    logic [NR:0]    valid;
    logic [W-1:0]   mem [NR+1];

    logic           wen;
    logic [4:0]     waddr;
    logic [W-1:0]   src;
    logic [W-1:0]   wdata;

    assign wen        = (state == LOAD) || (state == EXPAND);
    assign waddr      = (state == LOAD) ? 5'd0 : rc;
    assign src        = (state == LOAD) ? mkey : rf_key_in;
    assign rf_key_out = chain;

`ifdef REMASK_STORE_EN
    logic [KW-1:0] rnd_acc;

    // Remask each share; the last share absorbs all masks so the XOR is preserved
    always_comb begin
        rnd_acc = '0;
        wdata   = src;
        for (int j = 0; j < SHARES - 1; j++) begin
            wdata[j*KW +: KW] = src[j*KW +: KW] ^ rnd[j*KW +: KW];
            rnd_acc           = rnd_acc ^ rnd[j*KW +: KW];
        end
        wdata[(SHARES-1)*KW +: KW] = src[(SHARES-1)*KW +: KW] ^ rnd_acc;
    end
`else
    logic unused_rnd;

    assign wdata      = src;
    assign unused_rnd = ^rnd;
`endif

    // Control FSM: sequences LOAD/EXPAND/DONE and owns the chain, rc and valid bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rc        <= 5'd0;
            chain     <= '0;
            valid     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_rc_ena <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        valid <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    valid[0]  <= 1'b1;
                    chain     <= mkey;
                    rc        <= 5'd1;
                    state     <= EXPAND;
                    rf_rc_ena <= 1'b1;
                end
                EXPAND: begin
                    valid[rc] <= 1'b1;
                    chain     <= rf_key_in;
                    rc        <= rc + 5'd1;
                    if (rc == 5'(NR)) begin
                        state     <= DONE;
                        rf_rc_ena <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Round-key storage; data is never reset, the valid bits gate it
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // One-cycle read port; invalid or out-of-range entries read as zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rk_rd_valid <= 1'b0;
            rk_rd_data  <= '0;
        end else begin
            rk_rd_valid <= rk_rd_en;
            if (rk_rd_en && (rk_rd_addr <= 5'(NR)) && valid[rk_rd_addr]) begin
                rk_rd_data <= mem[rk_rd_addr];
            end else begin
                rk_rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_shared_key_schedule_ctrl.sv
// Testbench for shared_key_schedule_ctrl: rotate-by-one round function,
// reference key schedule computed by direct rotation of each share.
module tb_shared_key_schedule_ctrl;

`ifdef REMASK_STORE_EN
    localparam int SH  = 3;
    localparam int KWB = 256;
`else
    localparam int SH  = 2;
    localparam int KWB = 128;
`endif
    localparam int NRB = 16;
    localparam int CW  = SH * KWB;
    localparam int RW  = (SH - 1) * KWB;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [CW-1:0] mkey;
    logic [RW-1:0] rnd;
    logic          busy;
    logic          done;
    logic [CW-1:0] rf_key_out;
    logic          rf_rc_ena;
    logic [CW-1:0] rf_key_in;
    logic          rk_rd_en;
    logic [4:0]    rk_rd_addr;
    logic [CW-1:0] rk_rd_data;
    logic          rk_rd_valid;

    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] key;
    logic [CW-1:0] rv;

    shared_key_schedule_ctrl #(
        .KW    (KWB),
        .SHARES(SH),
        .NR    (NRB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .mkey       (mkey),
        .rnd        (rnd),
        .busy       (busy),
        .done       (done),
        .rf_key_out (rf_key_out),
        .rf_rc_ena  (rf_rc_ena),
        .rf_key_in  (rf_key_in),
        .rk_rd_en   (rk_rd_en),
        .rk_rd_addr (rk_rd_addr),
        .rk_rd_data (rk_rd_data),
        .rk_rd_valid(rk_rd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [KWB-1:0] rotl(input logic [KWB-1:0] x, input int n);
        int m;
        m = n % KWB;
        if (m == 0) return x;
        return (x << m) | (x >> (KWB - m));
    endfunction

    // Reference: entry r holds every share of the master key rotated left by r
    function automatic logic [CW-1:0] ref_entry(input logic [CW-1:0] k, input int r);
        logic [CW-1:0] v;
        v = '0;
        for (int j = 0; j < SH; j++) v[j*KWB +: KWB] = rotl(k[j*KWB +: KWB], r);
        return v;
    endfunction

    function automatic logic [CW-1:0] rand_vec();
        logic [CW-1:0] v;
        v = '0;
        for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

`ifdef REMASK_STORE_EN
    function automatic logic [KWB-1:0] xor_sh(input logic [CW-1:0] v);
        logic [KWB-1:0] acc;
        acc = '0;
        for (int j = 0; j < SH; j++) acc = acc ^ v[j*KWB +: KWB];
        return acc;
    endfunction
`endif

    // Bench round function: rotate each share left by one
    always_comb begin
        rf_key_in = '0;
        for (int j = 0; j < SH; j++) rf_key_in[j*KWB +: KWB] = rotl(rf_key_out[j*KWB +: KWB], 1);
    end

    // Fresh randomness every cycle
    always @(negedge clk) begin
        rv  = rand_vec();
        rnd = rv[RW-1:0];
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input string tag, input logic [CW-1:0] obs, input int r);
`ifdef REMASK_STORE_EN
        check(tag, CW'(xor_sh(obs)), CW'(xor_sh(ref_entry(key, r))));
`else
        check(tag, obs, ref_entry(key, r));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readout(input string tag, input bit reverse, output int ndiff);
        int a;
        ndiff = 0;
        for (int i = 0; i <= NRB; i++) begin
            a          = reverse ? NRB - i : i;
            rk_rd_en   = 1'b1;
            rk_rd_addr = 5'(a);
            tick();
            check($sformatf("%s_valid%0d", tag, a), CW'(rk_rd_valid), CW'(1));
            check_entry($sformatf("%s_data%0d", tag, a), rk_rd_data, a);
            if (rk_rd_data !== ref_entry(key, a)) ndiff++;
        end
        rk_rd_en = 1'b0;
    endtask

    task automatic run_expansion(input string tag);
        int nb;
        int nd;
        int ne;
        int first;
        nb    = 0;
        nd    = 0;
        ne    = 0;
        first = 0;
        mkey  = key;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= NRB + 8; cyc++) begin
            if (busy) nb++;
            if (rf_rc_ena) ne++;
            if (done) begin
                nd++;
                if (first == 0) first = cyc;
            end
            tick();
        end
        check({tag, "_done_cyc"}, CW'(first), CW'(NRB + 2));
        check({tag, "_ndone"}, CW'(nd), CW'(1));
        check({tag, "_busy_cycles"}, CW'(nb), CW'(NRB + 2));
        check({tag, "_ena_cycles"}, CW'(ne), CW'(NRB));
    endtask

    initial begin
        int nb;
        int nd;
        int ne;
        int first;
        int ndiff;

        rstn       = 1'b0;
        start      = 1'b0;
        mkey       = '0;
        rk_rd_en   = 1'b0;
        rk_rd_addr = 5'd0;
        rv         = rand_vec();
        rnd        = rv[RW-1:0];
        repeat (3) tick();

        // Reset state
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_done", CW'(done), CW'(0));
        check("rst_ena", CW'(rf_rc_ena), CW'(0));
        check("rst_rd_valid", CW'(rk_rd_valid), CW'(0));
        check("rst_rd_data", rk_rd_data, '0);
        check("rst_key_out", rf_key_out, '0);
        rstn = 1'b1;
        tick();

        // Directed expansion with mid-run reads and ignored starts
        key                = '0;
        key[KWB-1:0]       = {(KWB / 64){64'h0123456789ABCDEF}};
        mkey               = key;
        nb                 = 0;
        nd                 = 0;
        ne                 = 0;
        first              = 0;
        start              = 1'b1;
        tick();
        start = 1'b0;
        check("load_key_out", rf_key_out, '0);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy) nb++;
            if (rf_rc_ena) ne++;
            if (done) begin
                nd++;
                if (first == 0) first = cyc;
            end
            if (cyc == 2) check("chain_mkey", rf_key_out, key);
            if (cyc == 5) begin
                check("rd5_valid", CW'(rk_rd_valid), CW'(1));
                check("rd5_data", rk_rd_data, '0);
            end
            if (cyc == 6) begin
                check("rd_same_valid", CW'(rk_rd_valid), CW'(1));
                check("rd_same_data", rk_rd_data, '0);
            end
            if (cyc == 7) begin
                check("idle_rd_valid", CW'(rk_rd_valid), CW'(0));
                check("idle_rd_data", rk_rd_data, '0);
            end
            if (cyc == 8) check_entry("mid_rd2", rk_rd_data, 2);
            start    = 1'b0;
            rk_rd_en = 1'b0;
            if (cyc == 4) begin
                start      = 1'b1;
                rk_rd_en   = 1'b1;
                rk_rd_addr = 5'd5;
            end
            if (cyc == 5) begin
                rk_rd_en   = 1'b1;
                rk_rd_addr = 5'd4;
            end
            if (cyc == 7) begin
                rk_rd_en   = 1'b1;
                rk_rd_addr = 5'd2;
            end
            if (done) start = 1'b1;
            tick();
        end
        start    = 1'b0;
        rk_rd_en = 1'b0;
        check("dir_done_cyc", CW'(first), CW'(NRB + 2));
        check("dir_ndone", CW'(nd), CW'(1));
        check("dir_busy_cycles", CW'(nb), CW'(NRB + 2));
        check("dir_ena_cycles", CW'(ne), CW'(NRB));

        // Reverse readout, then out-of-range address
        readout("rev", 1'b1, ndiff);
`ifdef REMASK_STORE_EN
        check("remask_diff", CW'(ndiff), CW'(NRB + 1));
`else
        check("nomask_diff", CW'(ndiff), CW'(0));
        rk_rd_en   = 1'b1;
        rk_rd_addr = 5'd16;
        tick();
        check("entry16_sh0", CW'(rk_rd_data[KWB-1:0]),
              CW'(128'h456789ABCDEF0123456789ABCDEF0123));
`endif
        rk_rd_en   = 1'b1;
        rk_rd_addr = 5'd17;
        tick();
        rk_rd_en = 1'b0;
        check("rd17_valid", CW'(rk_rd_valid), CW'(1));
        check("rd17_data", rk_rd_data, '0);

        // Randomized expansions with forward readout
        for (int n = 0; n < 3; n++) begin
            key = rand_vec();
            run_expansion($sformatf("rand%0d", n));
            readout($sformatf("fwd%0d", n), 1'b0, ndiff);
        end

        // Reset in the middle of an expansion
        key   = rand_vec();
        mkey  = key;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rk_rd_en   = 1'b1;
        rk_rd_addr = 5'd0;
        tick();
        rk_rd_en = 1'b0;
        check("pre_rst_busy", CW'(busy), CW'(1));
        check("pre_rst_valid", CW'(rk_rd_valid), CW'(1));
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", CW'(busy), CW'(0));
        check("mid_rst_done", CW'(done), CW'(0));
        check("mid_rst_ena", CW'(rf_rc_ena), CW'(0));
        check("mid_rst_valid", CW'(rk_rd_valid), CW'(0));
        check("mid_rst_data", rk_rd_data, '0);
        check("mid_rst_key", rf_key_out, '0);
        nd = 0;
        repeat (3) begin
            tick();
            if (done) nd++;
        end
        rstn = 1'b1;
        repeat (NRB + 4) begin
            tick();
            if (done) nd++;
        end
        check("abort_ndone", CW'(nd), CW'(0));
        check("abort_busy", CW'(busy), CW'(0));
        rk_rd_en   = 1'b1;
        rk_rd_addr = 5'd3;
        tick();
        rk_rd_en = 1'b0;
        check("post_rst_rd3_valid", CW'(rk_rd_valid), CW'(1));
        check("post_rst_rd3_data", rk_rd_data, '0);
        key = rand_vec();
        run_expansion("post_rst");
        readout("post_rst_fwd", 1'b0, ndiff);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
